// File: rtl/gate_checker.sv
// gate_checker: sweeps all eight 3-input vectors into a gate, samples its output and checks it against TRUTH.
module gate_checker #(
    parameter logic [7:0] TRUTH = 8'b0000_0001,
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       x,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] first_fail
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;
    state_t state, state_n;
    logic [2:0] vec, vec_n, first_fail_n;
    logic [3:0] cnt, cnt_n, err_count_n;
    logic fail_valid_n, mismatch;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            vec <= '0;
            cnt <= '0;
            err_count <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else begin
            state <= state_n;
            vec <= vec_n;
            cnt <= cnt_n;
            err_count <= err_count_n;
            fail_valid <= fail_valid_n;
            first_fail <= first_fail_n;
        end
    end
    assign mismatch = x != TRUTH[vec];
    always_comb begin
        state_n = state;
        vec_n = vec;
        cnt_n = cnt;
        err_count_n = err_count;
        fail_valid_n = fail_valid;
        first_fail_n = first_fail;
        case (state)
            S_IDLE, S_DONE: if (start) begin
                state_n = S_SETTLE;
                vec_n = '0;
                cnt_n = '0;
                err_count_n = '0;
                fail_valid_n = 1'b0;
                first_fail_n = '0;
            end
            S_SETTLE: begin
                state_n = (cnt == 4'(SETTLE - 1)) ? S_CHECK : S_SETTLE;
                cnt_n = (cnt == 4'(SETTLE - 1)) ? 4'd0 : cnt + 4'd1;
            end
            default: begin
                err_count_n = mismatch ? err_count + 4'd1 : err_count;
                fail_valid_n = fail_valid | mismatch;
                first_fail_n = (mismatch && !fail_valid) ? vec : first_fail;
                state_n = (vec == 3'd7) ? S_DONE : S_SETTLE;
                vec_n = (vec == 3'd7) ? vec : vec + 3'd1;
            end
        endcase
    end
    // Stimulus is decoded only from registered state, so vectors switch cleanly on a clock edge.
    assign busy = (state == S_SETTLE) || (state == S_CHECK);
    assign done = state == S_DONE;
    assign pass = done && (err_count == 4'd0);
    assign {a, b, c} = busy ? vec : 3'd0;
endmodule

// File: tb/tb_gate_checker.sv
// tb_gate_checker: directed checks of gate_checker with default and 8'h80/SETTLE=1 configurations.
module tb_gate_checker;
    logic clk = 1'b0, rst = 1'b1, st = 1'b0, sel = 1'b0;
    int mode = 0;
    int checks = 0, errors = 0;
    logic a1, b1, c1, x1, busy1, done1, pass1, fv1;
    logic a2, b2, c2, x2, busy2, done2, pass2, fv2;
    logic [3:0] err1, err2;
    logic [2:0] ff1, ff2;
    logic [2:0] abc;
    logic busy, done, pass, fv;
    logic [3:0] err;
    logic [2:0] ff;

    always #5 clk = ~clk;

    function automatic logic model(int m, logic [2:0] v);
        case (m)
            0: return ~|v;
            1: return 1'b0;
            2: return 1'b1;
            3: return |v;
            default: return &v;
        endcase
    endfunction

    assign x1 = model(mode, {a1, b1, c1});
    assign x2 = model(mode, {a2, b2, c2});

    gate_checker dut (
        .clk(clk), .rst(rst), .start(st & ~sel), .a(a1), .b(b1), .c(c1), .x(x1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .first_fail(ff1)
    );

    gate_checker #(.TRUTH(8'h80), .SETTLE(1)) dut2 (
        .clk(clk), .rst(rst), .start(st & sel), .a(a2), .b(b2), .c(c2), .x(x2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_valid(fv2), .first_fail(ff2)
    );

    assign abc = sel ? {a2, b2, c2} : {a1, b1, c1};
    assign busy = sel ? busy2 : busy1;
    assign done = sel ? done2 : done1;
    assign pass = sel ? pass2 : pass1;
    assign err = sel ? err2 : err1;
    assign fv = sel ? fv2 : fv1;
    assign ff = sel ? ff2 : ff1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 8'(busy), 8'd0);
        chk({tag, "_done"}, 8'(done), 8'd0);
        chk({tag, "_pass"}, 8'(pass), 8'd0);
        chk({tag, "_abc"}, 8'(abc), 8'd0);
        chk({tag, "_err"}, 8'(err), 8'd0);
        chk({tag, "_fv"}, 8'(fv), 8'd0);
        chk({tag, "_ff"}, 8'(ff), 8'd0);
    endtask

    // Starts a sweep and checks every cycle of it; optional stray start pulses at cycles 5 and 12.
    task automatic sweep(input string tag, input int m, input int len, input int per, input bit stray,
                         input logic [3:0] e_err, input logic e_fv, input logic [2:0] e_ff, input logic e_pass);
        mode = m;
        st = 1'b1;
        tick();
        st = 1'b0;
        chk({tag, "_done_clr"}, 8'(done), 8'd0);
        for (int k = 0; k < len; k++) begin
            chk({tag, "_busy"}, 8'(busy), 8'd1);
            chk({tag, "_vec"}, 8'(abc), 8'(k / per));
            st = stray && (k == 5 || k == 12);
            tick();
            st = 1'b0;
        end
        chk({tag, "_end_busy"}, 8'(busy), 8'd0);
        chk({tag, "_end_done"}, 8'(done), 8'd1);
        chk({tag, "_end_abc"}, 8'(abc), 8'd0);
        chk({tag, "_pass"}, 8'(pass), 8'(e_pass));
        chk({tag, "_err"}, 8'(err), 8'(e_err));
        chk({tag, "_fv"}, 8'(fv), 8'(e_fv));
        chk({tag, "_ff"}, 8'(ff), 8'(e_ff));
    endtask

    initial begin
        tick();
        tick();
        chk_idle("rst1");
        sel = 1'b1;
        chk_idle("rst2");
        sel = 1'b0;
        rst = 1'b0;
        tick();
        chk_idle("idle");
        sweep("nor", 0, 24, 3, 1'b0, 4'd0, 1'b0, 3'd0, 1'b1);
        sweep("tie0", 1, 24, 3, 1'b0, 4'd1, 1'b1, 3'd0, 1'b0);
        sweep("tie1", 2, 24, 3, 1'b0, 4'd7, 1'b1, 3'd1, 1'b0);
        sweep("or", 3, 24, 3, 1'b0, 4'd8, 1'b1, 3'd0, 1'b0);
        sweep("stray", 0, 24, 3, 1'b1, 4'd0, 1'b0, 3'd0, 1'b1);
        // Abort a failing sweep at cycle 10, with start asserted alongside reset.
        mode = 1;
        st = 1'b1;
        tick();
        st = 1'b0;
        repeat (10) tick();
        chk("mid_err", 8'(err), 8'd1);
        chk("mid_fv", 8'(fv), 8'd1);
        chk("mid_busy", 8'(busy), 8'd1);
        rst = 1'b1;
        st = 1'b1;
        tick();
        rst = 1'b0;
        st = 1'b0;
        chk_idle("abort");
        tick();
        chk_idle("abort_idle");
        sweep("post_rst", 0, 24, 3, 1'b0, 4'd0, 1'b0, 3'd0, 1'b1);
        // Start held high: done lasts exactly one cycle before the next sweep.
        mode = 0;
        st = 1'b1;
        repeat (25) tick();
        chk("held_done", 8'(done), 8'd1);
        chk("held_pass", 8'(pass), 8'd1);
        tick();
        st = 1'b0;
        chk("held_restart_busy", 8'(busy), 8'd1);
        chk("held_restart_done", 8'(done), 8'd0);
        repeat (24) tick();
        chk("held_end_done", 8'(done), 8'd1);
        sel = 1'b1;
        sweep("and80", 4, 16, 2, 1'b0, 4'd0, 1'b0, 3'd0, 1'b1);
        sweep("nor80", 0, 16, 2, 1'b0, 4'd2, 1'b1, 3'd0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
